coeff_frame_loader: RTL and testbench

- Writer side of the filter coefficient frame interface.
- Accepts a 32-bit word stream on a valid/ready handshake and parses coefficient frames. Each frame is a header, 4 zero words, 4 pole words and an XOR checksum.
- On a good frame, presents all 8 coefficients in parallel and pulses frame_done for one cycle, so the downstream coefficient frame register latches them.
- Bad or stalled frames are discarded; previously committed coefficients stay on the outputs.

---
 rtl/coeff_frame_loader.sv | 124 ++++++++++++
 tb/tb_coeff_frame_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_frame_loader.sv
// Writer side of the filter coefficient frame interface: parses HEADER + 8 data words + XOR
// checksum from a valid/ready stream and commits the coefficients in parallel on a good frame.
module coeff_frame_loader #(
    parameter logic [31:0] HEADER  = 32'hC0EF_F00D,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] zero_0,
    output logic [31:0] zero_1,
    output logic [31:0] zero_2,
    output logic [31:0] zero_3,
    output logic [31:0] pole_0,
    output logic [31:0] pole_1,
    output logic [31:0] pole_2,
    output logic [31:0] pole_3,
    output logic        frame_done,
    output logic        err_csum,
    output logic        err_timeout,
    output logic [7:0]  frame_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] CSUM   = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    localparam logic [15:0] GAP_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_MAX  = 16'(TIMEOUT);

    logic [1:0]  state;
    logic [2:0]  idx;
    logic [31:0] xor_acc;
    logic [15:0] gap;
    logic [31:0] shadow [8];
    logic        accept;

    assign in_ready = (state != COMMIT);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            xor_acc     <= '0;
            gap         <= '0;
            for (int unsigned i = 0; i < 8; i++) shadow[i] <= '0;
            zero_0      <= '0;
            zero_1      <= '0;
            zero_2      <= '0;
            zero_3      <= '0;
            pole_0      <= '0;
            pole_1      <= '0;
            pole_2      <= '0;
            pole_3      <= '0;
            frame_done  <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done  <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && in_data == HEADER) begin
                        state   <= LOAD;
                        idx     <= '0;
                        xor_acc <= '0;
                        gap     <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shadow[idx] <= in_data;
                        xor_acc     <= xor_acc ^ in_data;
                        idx         <= idx + 3'd1;
                        gap         <= '0;
                        if (idx == 3'd7) state <= CSUM;
                    end else if (gap >= GAP_LAST) begin
                        gap         <= GAP_MAX;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        gap <= gap + 16'd1;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        gap <= '0;
                        if (in_data == xor_acc) begin
                            // Outputs load on the edge entering COMMIT so they are valid with frame_done.
                            zero_0      <= shadow[0];
                            zero_1      <= shadow[1];
                            zero_2      <= shadow[2];
                            zero_3      <= shadow[3];
                            pole_0      <= shadow[4];
                            pole_1      <= shadow[5];
                            pole_2      <= shadow[6];
                            pole_3      <= shadow[7];
                            frame_count <= frame_count + 8'd1;
                            frame_done  <= 1'b1;
                            state       <= COMMIT;
                        end else begin
                            err_csum <= 1'b1;
                            state    <= IDLE;
                        end
                    end else if (gap >= GAP_LAST) begin
                        gap         <= GAP_MAX;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        gap <= gap + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_frame_loader.sv
// Scoreboard bench for coeff_frame_loader: expected commits are queued as frames are sent
// and popped when frame_done is observed.
module tb_coeff_frame_loader;

    localparam logic [31:0] HDR = 32'hC0EF_F00D;
    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] zero_0, zero_1, zero_2, zero_3;
    logic [31:0] pole_0, pole_1, pole_2, pole_3;
    logic        frame_done, err_csum, err_timeout;
    logic [7:0]  frame_count;

    typedef struct packed {
        logic [255:0] c;
        logic [7:0]   cnt;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] held;
    logic [7:0]   exp_cnt;
    int checks = 0;
    int errors = 0;
    int n_done = 0, n_csum = 0, n_tmo = 0, n_multi = 0;

    coeff_frame_loader #(.HEADER(HDR), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .zero_0(zero_0), .zero_1(zero_1), .zero_2(zero_2), .zero_3(zero_3),
        .pole_0(pole_0), .pole_1(pole_1), .pole_2(pole_2), .pole_3(pole_3),
        .frame_done(frame_done), .err_csum(err_csum), .err_timeout(err_timeout),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done === 1'b1) n_done++;
            if (err_csum === 1'b1) n_csum++;
            if (err_timeout === 1'b1) n_tmo++;
            if (32'(frame_done) + 32'(err_csum) + 32'(err_timeout) > 1) n_multi++;
        end
    end

    function automatic logic [255:0] outs();
        return {pole_3, pole_2, pole_1, pole_0, zero_3, zero_2, zero_1, zero_0};
    endfunction

    function automatic logic [255:0] seq(input logic [31:0] base);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = base + 32'(i);
        return d;
    endfunction

    function automatic logic [31:0] xor8(input logic [255:0] d);
        logic [31:0] x = '0;
        for (int i = 0; i < 8; i++) x ^= d[i*32 +: 32];
        return x;
    endfunction

    task automatic send_word(input logic [31:0] w);
        logic rdy = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 16 && !rdy; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_word: in_ready stayed 0 for 16 cycles, required 1");
        end
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [255:0] d, input logic [31:0] csum, input int gap);
        exp_t e;
        int d0 = n_done, c0 = n_csum, t0 = n_tmo;
        logic good = (xor8(d) == csum);
        send_word(HDR);
        idle_cycles(gap);
        for (int i = 0; i < 8; i++) begin
            send_word(d[i*32 +: 32]);
            idle_cycles(gap);
        end
        if (good) begin
            exp_cnt = exp_cnt + 8'd1;
            e.c = d;
            e.cnt = exp_cnt;
            sb.push_back(e);
        end
        send_word(csum);
        if (good) begin
            e = sb.pop_front();
            checks++;
            if (frame_done !== 1'b1) begin
                errors++; $display("FAIL commit_done: frame_done=%b required 1", frame_done);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL commit_ready: in_ready=%b required 0", in_ready);
            end
            checks++;
            if (outs() !== e.c) begin
                errors++; $display("FAIL commit_coeffs: got %h required %h", outs(), e.c);
            end
            checks++;
            if (frame_count !== e.cnt) begin
                errors++; $display("FAIL commit_count: frame_count=%0d required %0d", frame_count, e.cnt);
            end
            held = e.c;
            idle_cycles(1);
            checks++;
            if (frame_done !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_commit: frame_done=%b in_ready=%b required 0/1", frame_done, in_ready);
            end
            checks++;
            if (n_done - d0 != 1 || n_csum != c0 || n_tmo != t0) begin
                errors++;
                $display("FAIL pulse_counts: done=%0d csum=%0d tmo=%0d required 1/0/0",
                         n_done - d0, n_csum - c0, n_tmo - t0);
            end
        end else begin
            checks++;
            if (err_csum !== 1'b1 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL bad_csum_pulse: err_csum=%b frame_done=%b required 1/0", err_csum, frame_done);
            end
            checks++;
            if (outs() !== held || frame_count !== exp_cnt) begin
                errors++;
                $display("FAIL bad_csum_hold: coeffs %h count %0d required %h count %0d",
                         outs(), frame_count, held, exp_cnt);
            end
            idle_cycles(1);
            checks++;
            if (err_csum !== 1'b0 || n_done != d0 || n_csum - c0 != 1) begin
                errors++;
                $display("FAIL bad_csum_single: err_csum=%b done_pulses=%0d csum_pulses=%0d required 0/0/1",
                         err_csum, n_done - d0, n_csum - c0);
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        held     = '0;
        exp_cnt  = '0;
        #12;
        checks++;
        if (outs() !== '0 || frame_count !== 8'd0) begin
            errors++; $display("FAIL reset_values: coeffs %h count %0d required 0", outs(), frame_count);
        end
        checks++;
        if (frame_done !== 1'b0 || err_csum !== 1'b0 || err_timeout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: done=%b csum=%b tmo=%b ready=%b required 0/0/0/1",
                     frame_done, err_csum, err_timeout, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        logic [255:0] d;
        send_frame(seq(32'd1), 32'd8, 0);
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        d[3*32 +: 32] = HDR;
        send_frame(d, xor8(d), 0);
    endtask

    task automatic test_bad_csum();
        send_frame(seq(32'd1), 32'd9, 0);
    endtask

    task automatic test_garbage();
        int c0 = n_csum, t0 = n_tmo, d0 = n_done;
        send_word(32'hDEAD_BEEF);
        send_word(32'h0);
        idle_cycles(1);
        checks++;
        if (n_csum != c0 || n_tmo != t0 || n_done != d0 || frame_count !== exp_cnt) begin
            errors++;
            $display("FAIL garbage_ignored: pulses csum=%0d tmo=%0d done=%0d count=%0d required 0/0/0/%0d",
                     n_csum - c0, n_tmo - t0, n_done - d0, frame_count, exp_cnt);
        end
        send_frame(seq(32'h10), 32'h0, 0);
    endtask

    task automatic test_timeout();
        logic [255:0] d;
        int early = 0;
        send_word(HDR);
        for (int i = 0; i < 3; i++) send_word(32'hA0 + 32'(i));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 8 && err_timeout !== 1'b0) early++;
        end
        checks++;
        if (early != 0 || err_timeout !== 1'b1 || frame_done !== 1'b0 || err_csum !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: early=%0d err_timeout=%b done=%b csum=%b required 0/1/0/0",
                     early, err_timeout, frame_done, err_csum);
        end
        idle_cycles(1);
        checks++;
        if (err_timeout !== 1'b0 || in_ready !== 1'b1 || outs() !== held || frame_count !== exp_cnt) begin
            errors++;
            $display("FAIL timeout_after: err_timeout=%b ready=%b count=%0d required 0/1/%0d",
                     err_timeout, in_ready, frame_count, exp_cnt);
        end
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        send_frame(d, xor8(d), 0);
    endtask

    task automatic test_gaps();
        send_frame(seq(32'h100), xor8(seq(32'h100)), 7);
    endtask

    task automatic test_reset_midframe();
        send_word(HDR);
        for (int i = 0; i < 5; i++) send_word(32'h55 + 32'(i));
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== '0 || frame_count !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midframe: coeffs %h count %0d ready %b required 0/0/1",
                     outs(), frame_count, in_ready);
        end
        #2;
        reset = 1'b0;
        held    = '0;
        exp_cnt = '0;
        idle_cycles(1);
        send_frame(seq(32'h200), xor8(seq(32'h200)), 0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bad_csum();
        test_garbage();
        test_timeout();
        test_gaps();
        test_reset_midframe();
        checks++;
        if (n_multi != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL pulse_exclusive: overlapping cycles=%0d pending=%0d required 0/0", n_multi, sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
